// File: rtl/grf_pkg.sv
// Shared definitions for the general-purpose register file (gen_reg_file).
package grf_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // Register $0 is hardwired to zero
    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/grf_read_port.sv
// Combinational read port for gen_reg_file: zero-register handling and,
// when GRF_BYPASS_EN is defined, same-cycle write-to-read forwarding.
module grf_read_port #(
    parameter int DATA_W = grf_pkg::DATA_W,
    parameter int ADDR_W = grf_pkg::ADDR_W
) (
    input  logic [DATA_W-1:0] regs [2**ADDR_W],
    input  logic [ADDR_W-1:0] ra,
`ifdef GRF_BYPASS_EN
    input  logic              reset,
    input  logic              regwrite,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
`endif
    output logic [DATA_W-1:0] rd
);
    import grf_pkg::*;

    // Select read data: $0 reads zero, forwarded write data wins over storage
    always_comb begin
        rd = regs[ra];
        if (ra == ADDR_W'(ZERO_REG)) begin
            rd = '0;
        end
`ifdef GRF_BYPASS_EN
        else if (!reset && regwrite && (wa == ra)) begin
            rd = wd;
        end
`endif
    end

endmodule

// File: rtl/gen_reg_file.sv
// General-purpose register file: 2**ADDR_W x DATA_W, two combinational
// read ports, one clocked write port, $0 hardwired to zero.
// Optional macro GRF_BYPASS_EN enables write-to-read forwarding.
module gen_reg_file #(
    parameter int DATA_W = grf_pkg::DATA_W,
    parameter int ADDR_W = grf_pkg::ADDR_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] WD,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2
);
    import grf_pkg::*;

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];

    // Synchronous clear has priority over the write port; writes to $0 dropped
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWrite && (WA != ADDR_W'(ZERO_REG))) begin
            regs[WA] <= WD;
        end
    end

    grf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rp1 (
        .regs     (regs),
        .ra       (RA1),
`ifdef GRF_BYPASS_EN
        .reset    (Reset),
        .regwrite (RegWrite),
        .wa       (WA),
        .wd       (WD),
`endif
        .rd       (RD1)
    );

    grf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rp2 (
        .regs     (regs),
        .ra       (RA2),
`ifdef GRF_BYPASS_EN
        .reset    (Reset),
        .regwrite (RegWrite),
        .wa       (WA),
        .wd       (WD),
`endif
        .rd       (RD2)
    );

endmodule

// File: tb/tb_gen_reg_file.sv
// Scoreboard testbench for gen_reg_file: directed plan plus random traffic,
// checked against an array-based reference model.
module tb_gen_reg_file;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        RegWrite = 1'b0;
    logic [4:0]  RA1 = '0;
    logic [4:0]  RA2 = '0;
    logic [4:0]  WA = '0;
    logic [31:0] WD = '0;
    logic [31:0] RD1;
    logic [31:0] RD2;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;

    logic [31:0] model [32];

    gen_reg_file #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .RegWrite (RegWrite),
        .RA1      (RA1),
        .RA2      (RA2),
        .WA       (WA),
        .WD       (WD),
        .RD1      (RD1),
        .RD2      (RD2)
    );

    always #5 Clock = ~Clock;

    // Reference read: what the architecture says a read returns right now
    function automatic logic [31:0] ref_read(input logic [4:0] ra);
        if (ra == 5'd0) return 32'd0;
`ifdef GRF_BYPASS_EN
        if (!Reset && RegWrite && WA != 5'd0 && WA == ra) return WD;
`endif
        return model[ra];
    endfunction

    // Queue the expectation for the current inputs and hand it to the monitor
    task automatic expect_now(input string name);
        exp_t e;
        e.name = name;
        e.e1 = ref_read(RA1);
        e.e2 = ref_read(RA2);
        exp_q.push_back(e);
        ->sample_ev;
        #0;
    endtask

    // One clock cycle: drive at negedge, check before and after the rising edge
    task automatic cycle(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] ra1,
                         input logic [4:0] ra2, input bit pre, input string name);
        @(negedge Clock);
        Reset = rst; RegWrite = we; WA = wa; WD = wd; RA1 = ra1; RA2 = ra2;
        #1;
        if (pre) expect_now({name, "_pre"});
        @(posedge Clock);
        if (rst) begin
            for (int k = 0; k < 32; k++) model[k] = 32'd0;
        end else if (we && wa != 5'd0) begin
            model[wa] = wd;
        end
        #1;
        expect_now({name, "_post"});
    endtask

    // Combinational-only read: change addresses with no clock edge in between
    task automatic read_only(input logic [4:0] ra1, input logic [4:0] ra2,
                             input string name);
        RA1 = ra1; RA2 = ra2;
        #1;
        expect_now(name);
    endtask

    // Monitor: pops the oldest expectation whenever a sample point is presented
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty: sample point with no expectation queued");
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (RD1 !== e.e1) begin
                    failures++;
                    $display("FAIL %s RD1 (RA1=%0d): got %h expected %h", e.name, RA1, RD1, e.e1);
                end
                checks++;
                if (RD2 !== e.e2) begin
                    failures++;
                    $display("FAIL %s RD2 (RA2=%0d): got %h expected %h", e.name, RA2, RD2, e.e2);
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int k = 0; k < 32; k++) model[k] = 32'd0;

        // Reset state: every address reads zero
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd1, 5'd31, 1'b0, "reset");
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd17, 5'd30, 1'b1, "reset_hold");

        // Fill/readback: reg[i] = i+1, watching 5 and 6
        for (int i = 0; i < 32; i++)
            cycle(1'b0, 1'b1, 5'(i), 32'(i + 1), 5'd5, 5'd6, 1'b1, $sformatf("fill%0d", i));
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd31, 1'b1, "reg0_reg31");

        // Write disabled: no change despite WA/WD activity
        cycle(1'b0, 1'b0, 5'd5, 32'd100, 5'd5, 5'd6, 1'b1, "wdis_a");
        cycle(1'b0, 1'b0, 5'd6, 32'd200, 5'd5, 5'd6, 1'b1, "wdis_b");

        // Read sweep between edges (pure combinational)
        @(negedge Clock);
        RegWrite = 1'b0;
        for (int i = 0; i < 8; i++)
            read_only(5'(i), 5'(31 - i), $sformatf("sweep%0d", i));
        for (int i = 8; i < 16; i++)
            cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b1, $sformatf("sweep%0d", i));

        // Synchronous reset mid-sweep
        for (int i = 16; i < 24; i++)
            cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b1, $sformatf("rsweep%0d", i));

        // Reset has priority over a simultaneous write
        cycle(1'b0, 1'b1, 5'd3, 32'h0000_0055, 5'd3, 5'd4, 1'b1, "prewrite3");
        cycle(1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF, 5'd3, 5'd4, 1'b1, "rst_vs_wr");
        // Writes to $0 are discarded
        cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1, "wr_zero");
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd3, 1'b1, "wr_zero_after");

        // Same-cycle read of the written address (forwarded or old value)
        cycle(1'b0, 1'b1, 5'd7, 32'h0000_5678, 5'd7, 5'd7, 1'b1, "bypass_seed");
        cycle(1'b0, 1'b1, 5'd7, 32'h0000_1234, 5'd7, 5'd8, 1'b1, "bypass");

        // Random traffic with occasional reset and address collisions
        for (int i = 0; i < 400; i++) begin
            logic [4:0] wa_r;
            wa_r = 5'($urandom_range(0, 31));
            cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), wa_r,
                  $urandom(),
                  ($urandom_range(0, 3) == 0) ? wa_r : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? wa_r : 5'($urandom_range(0, 31)),
                  1'b1, $sformatf("rand%0d", i));
        end

        // Drain the scoreboard with a bounded wait
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
